// File: rtl/adc_channel_scheduler.sv
// adc_channel_scheduler
//   Round-robin scheduler sharing one external I2C ADC between up to four analog
//   channels. Selects the ADC channel, waits out switch settling, drops the first
//   conversion after a switch and hands tagged 12-bit samples downstream over
//   valid/ready.
//
// Ports
//   clk, rst       : clock, asynchronous active-low reset
//   enable         : scheduling run enable
//   ch_mask        : channel enable mask (bit i = channel i), sampled in SELECT only
//   adc_data       : conversion result from the ADC I2C controller
//   adc_done       : one-cycle pulse, adc_data holds a new conversion
//   adc_channel    : channel select to the ADC I2C controller
//   sample_data    : captured sample
//   sample_ch      : channel tag of sample_data
//   sample_valid   : sample available (held until sample_ready)
//   sample_ready   : downstream accepts sample
//   err_timeout    : sticky, a channel produced no conversion in time
//   clr_err        : synchronous clear of err_timeout (a same-cycle set wins)
module adc_channel_scheduler #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [11:0]       adc_data,
    input  logic              adc_done,
    output logic [1:0]        adc_channel,
    output logic [11:0]       sample_data,
    output logic [1:0]        sample_ch,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              err_timeout,
    input  logic              clr_err
);

    localparam int unsigned SettleW  = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TimeoutW = $clog2(TIMEOUT_CYC);
    localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SETTLE_CYC - 1);
    localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StSelect,
        StSettle,
        StDiscard,
        StCapture,
        StOutput
    } state_e;

    state_e state_q, state_d;

    logic [1:0]          adc_channel_q, adc_channel_d;
    logic [1:0]          last_q, last_d;
    logic [11:0]         sample_data_q, sample_data_d;
    logic [1:0]          sample_ch_q, sample_ch_d;
    logic                sample_valid_q, sample_valid_d;
    logic                err_q, err_d;
    logic [SettleW-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TimeoutW-1:0] to_cnt_q, to_cnt_d;

    logic       settle_done, to_done, capture, timeout, waiting;
    logic [3:0] mask_ext;
    logic [1:0] next_ch, cand;
    logic       next_found;

    assign mask_ext    = 4'(ch_mask);
    assign settle_done = (settle_cnt_q == SettleLast);
    assign to_done     = (to_cnt_q == TimeoutLast);
    assign waiting     = (state_q == StDiscard) || (state_q == StCapture);
    assign capture     = (state_q == StCapture) && enable && adc_done;
    // adc_done on the terminal count is still a valid conversion, so it beats the timeout.
    assign timeout     = waiting && enable && !adc_done && to_done;

    // First enabled channel after the last serviced one, wrapping modulo NUM_CH.
    always_comb begin
        next_ch    = adc_channel_q;
        next_found = 1'b0;
        cand       = 2'd0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = 2'((32'(last_q) + k) % NUM_CH);
            if (!next_found && mask_ext[cand]) begin
                next_ch    = cand;
                next_found = 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (enable && (|ch_mask)) state_d = StSelect;
            end
            StSelect: begin
                if (!next_found)                    state_d = StIdle;
                else if (next_ch == adc_channel_q)  state_d = StCapture;
                else                                state_d = StSettle;
            end
            StSettle: begin
                if (!enable)          state_d = StIdle;
                else if (settle_done) state_d = StDiscard;
            end
            StDiscard: begin
                if (!enable)       state_d = StIdle;
                else if (adc_done) state_d = StCapture;
                else if (to_done)  state_d = StSelect;
            end
            StCapture: begin
                if (!enable)       state_d = StIdle;
                else if (adc_done) state_d = StOutput;
                else if (to_done)  state_d = StSelect;
            end
            StOutput: begin
                // Valid is never withdrawn: leave only on the handshake.
                if (sample_ready) state_d = enable ? StSelect : StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        adc_channel_d  = adc_channel_q;
        last_d         = last_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = sample_valid_q;
        err_d          = err_q;
        settle_cnt_d   = '0;
        to_cnt_d       = '0;

        case (state_q)
            StSelect: begin
                if (next_found && (next_ch != adc_channel_q)) adc_channel_d = next_ch;
            end
            StSettle: begin
                settle_cnt_d = settle_done ? settle_cnt_q : settle_cnt_q + SettleW'(1);
            end
            StDiscard, StCapture: begin
                // Clears on every entry (including DISCARD -> CAPTURE), saturates otherwise.
                if (state_d == state_q) begin
                    to_cnt_d = to_done ? to_cnt_q : to_cnt_q + TimeoutW'(1);
                end
            end
            StOutput: begin
                if (sample_ready) sample_valid_d = 1'b0;
            end
            default: ;
        endcase

        if (capture) begin
            sample_data_d  = adc_data;
            sample_ch_d    = adc_channel_q;
            sample_valid_d = 1'b1;
            last_d         = adc_channel_q;
        end

        if (timeout) last_d = adc_channel_q;

        if (clr_err) err_d = 1'b0;
        if (timeout) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            adc_channel_q  <= 2'd0;
            last_q         <= 2'(NUM_CH - 1);
            sample_data_q  <= 12'd0;
            sample_ch_q    <= 2'd0;
            sample_valid_q <= 1'b0;
            err_q          <= 1'b0;
            settle_cnt_q   <= '0;
            to_cnt_q       <= '0;
        end else begin
            adc_channel_q  <= adc_channel_d;
            last_q         <= last_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            settle_cnt_q   <= settle_cnt_d;
            to_cnt_q       <= to_cnt_d;
        end
    end

    assign adc_channel  = adc_channel_q;
    assign sample_data  = sample_data_q;
    assign sample_ch    = sample_ch_q;
    assign sample_valid = sample_valid_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_adc_channel_scheduler.sv
module tb_adc_channel_scheduler;

    localparam int unsigned NUM_CH      = 4;
    localparam int unsigned SETTLE_CYC  = 4;
    localparam int unsigned TIMEOUT_CYC = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              enable;
    logic [NUM_CH-1:0] ch_mask;
    logic [11:0]       adc_data;
    logic              adc_done;
    logic [1:0]        adc_channel;
    logic [11:0]       sample_data;
    logic [1:0]        sample_ch;
    logic              sample_valid;
    logic              sample_ready;
    logic              err_timeout;
    logic              clr_err;

    int tests = 0;
    int fails = 0;

    // Expected {channel, data} of each transfer, pushed when the captured conversion is driven.
    logic [13:0] exp_q[$];

    adc_channel_scheduler #(
        .NUM_CH      (NUM_CH),
        .SETTLE_CYC  (SETTLE_CYC),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .ch_mask      (ch_mask),
        .adc_data     (adc_data),
        .adc_done     (adc_done),
        .adc_channel  (adc_channel),
        .sample_data  (sample_data),
        .sample_ch    (sample_ch),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .err_timeout  (err_timeout),
        .clr_err      (clr_err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic adc_pulse(input logic [11:0] d);
        adc_data = d;
        adc_done = 1'b1;
        tick(1);
        adc_done = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted transfer must match the oldest expected sample.
    always @(negedge clk) begin
        if (rst && sample_valid && sample_ready) begin
            logic [13:0] exp_s;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $error("FAIL unexpected_sample: observed ch%0d %0h expected none",
                       sample_ch, sample_data);
            end else begin
                exp_s = exp_q.pop_front();
                assert ({sample_ch, sample_data} === exp_s) else begin
                    fails++;
                    $error("FAIL sample: observed ch%0d %0h expected ch%0d %0h",
                           sample_ch, sample_data, exp_s[13:12], exp_s[11:0]);
                end
            end
        end
    end

    initial begin
        rst          = 1'b0;
        enable       = 1'b0;
        ch_mask      = '0;
        adc_data     = 12'd0;
        adc_done     = 1'b0;
        sample_ready = 1'b0;
        clr_err      = 1'b0;

        // Reset values
        tick(3);
        check("rst_adc_channel", 32'(adc_channel), 32'd0);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_data", 32'(sample_data), 32'd0);
        check("rst_ch", 32'(sample_ch), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        rst = 1'b1;
        tick(1);

        // Mask 0101: ch0 first (no switch), then alternate with settle + discard
        ch_mask      = 4'b0101;
        sample_ready = 1'b1;
        enable       = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick(99);
            if (i % 2 == 0) begin
                exp_q.push_back({((i / 2) % 2 == 1) ? 2'd2 : 2'd0, 12'(12'h100 + i)});
                adc_pulse(12'(12'h100 + i));
                check("rr_valid_rise", 32'(sample_valid), 32'd1);
            end else begin
                adc_pulse(12'(12'h100 + i));
                check("rr_switch_ch", 32'(adc_channel), (i % 4 == 1) ? 32'd2 : 32'd0);
            end
        end
        tick(5);
        enable = 1'b0;
        tick(3);
        check("rr_idle_ch", 32'(adc_channel), 32'd0);

        // Mask 0001: immediate capture, one sample per adc_done at minimum gap
        ch_mask = 4'b0001;
        enable  = 1'b1;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({2'd0, 12'(12'h200 + i)});
            adc_pulse(12'(12'h200 + i));
            check("single_ch", 32'(adc_channel), 32'd0);
            tick(2);
        end

        // Backpressure: valid and payload held, extra conversions dropped
        sample_ready = 1'b0;
        exp_q.push_back({2'd0, 12'h3a5});
        adc_pulse(12'h3a5);
        for (int i = 0; i < 10; i++) begin
            tick(49);
            adc_pulse(12'hbad);
            check("bp_valid", 32'(sample_valid), 32'd1);
            check("bp_data", 32'(sample_data), 32'h3a5);
        end
        sample_ready = 1'b1;
        tick(1);
        check("bp_valid_fall", 32'(sample_valid), 32'd0);
        tick(1);
        exp_q.push_back({2'd0, 12'h3a6});
        adc_pulse(12'h3a6);
        tick(1);

        // Timeout: ch1 never converts
        enable = 1'b0;
        tick(2);
        ch_mask = 4'b0011;
        enable  = 1'b1;
        tick(100);
        check("to_ch1", 32'(adc_channel), 32'd1);
        tick(161);
        check("to_err_before", 32'(err_timeout), 32'd0);
        tick(1);
        check("to_err_set", 32'(err_timeout), 32'd1);
        tick(1);
        check("to_move_ch0", 32'(adc_channel), 32'd0);
        clr_err = 1'b1;
        tick(1);
        check("to_err_clr", 32'(err_timeout), 32'd0);
        tick(258);
        check("to_err_held_clr", 32'(err_timeout), 32'd0);
        tick(1);
        check("to_set_wins", 32'(err_timeout), 32'd1);
        tick(1);
        check("to_err_clr2", 32'(err_timeout), 32'd0);
        clr_err = 1'b0;

        // Disable in SETTLE: no sample
        enable = 1'b0;
        tick(2);
        for (int i = 0; i < 3; i++) begin
            adc_pulse(12'h0ee);
            tick(4);
        end
        check("dis_settle_valid", 32'(sample_valid), 32'd0);

        // Disable in OUTPUT: sample still transferred, then idle
        sample_ready = 1'b0;
        enable       = 1'b1;
        tick(2);
        exp_q.push_back({2'd1, 12'h4c1});
        adc_pulse(12'h4c1);
        enable = 1'b0;
        tick(3);
        check("dis_out_valid", 32'(sample_valid), 32'd1);
        check("dis_out_ch", 32'(sample_ch), 32'd1);
        sample_ready = 1'b1;
        tick(1);
        check("dis_out_fall", 32'(sample_valid), 32'd0);
        adc_pulse(12'h0ef);
        tick(5);
        adc_pulse(12'h0ef);
        check("dis_out_idle", 32'(sample_valid), 32'd0);

        // Async reset mid-CAPTURE
        ch_mask = 4'b0010;
        enable  = 1'b1;
        tick(2);
        check("pre_rst_ch", 32'(adc_channel), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_adc_channel", 32'(adc_channel), 32'd0);
        check("arst_data", 32'(sample_data), 32'd0);
        check("arst_ch", 32'(sample_ch), 32'd0);
        check("arst_valid", 32'(sample_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        ch_mask = 4'b1000;
        tick(10);
        adc_pulse(12'h0dd);
        check("post_rst_ch3", 32'(adc_channel), 32'd3);
        tick(3);
        exp_q.push_back({2'd3, 12'h5d3});
        adc_pulse(12'h5d3);
        tick(3);

        check("all_samples_seen", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
